// File: rtl/uart_tx.sv
// uart_tx: 8n1 serial transmitter with a running checksum of accepted bytes.
// Frames carry one start bit (low), eight data bits LSB first, then
// stop_bits stop bits (high). Each bit is held for cycles_per_bit clocks.
//
// Optional build macro UART_TX_FIFO_EN puts a fifo_depth-entry FIFO in front
// of the serialiser. Without it, a byte can only be taken while idle or in
// the last stop-bit cycle of the current frame.
//
// Every output is decoded from registered state only. No combinational path
// runs from tick_req or tick_data_in to any output.

module uart_tx #(
  parameter int cycles_per_bit = 4,
  parameter int stop_bits      = 1,
  parameter int fifo_depth     = 4
) (
  input  logic        clock,
  input  logic        tick_reset_n,
  input  logic [7:0]  tick_data_in,
  input  logic        tick_req,
  output logic        get_cts_ret,
  output logic        get_serial_ret,
  output logic        get_idle_ret,
  output logic [31:0] get_checksum_ret
);

  // Reject unusable parameter sets when the design is elaborated.
  if (cycles_per_bit < 2 || stop_bits < 1 || stop_bits > 2 ||
      fifo_depth < 2 || (fifo_depth & (fifo_depth - 1)) != 0) begin : g_bad_params
    $error("uart_tx: invalid parameters");
  end

  localparam int bd_w = $clog2(cycles_per_bit);
  localparam logic [bd_w-1:0] bd_last   = bd_w'(cycles_per_bit - 1);
  localparam logic            stop_last = 1'(stop_bits - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          state, state_n;
  logic [bd_w-1:0] bit_delay, bit_delay_n;
  logic [2:0]      bit_index, bit_index_n;
  logic [7:0]      shift, shift_n;
  logic            stop_cnt, stop_cnt_n;
  logic            ready;
  logic [31:0]     checksum;

  logic            final_stop;
  logic            can_load;
  logic            cts;
  logic            accept;
  logic            load;
  logic [7:0]      load_data;
  logic            fifo_empty;

  // The serialiser can take a new byte while idle or in the last stop cycle.
  // ready holds cts low during reset and goes high on the first edge after.
  assign final_stop = (state == STOP) && (bit_delay == bd_last) && (stop_cnt == stop_last);
  assign can_load   = ready && ((state == IDLE) || final_stop);
  assign accept     = tick_req && cts;

`ifdef UART_TX_FIFO_EN
  localparam int ptr_w = $clog2(fifo_depth) + 1;

  logic [7:0]       mem [fifo_depth];
  logic [ptr_w-1:0] wr_ptr;
  logic [ptr_w-1:0] rd_ptr;
  logic             fifo_full;
  logic             bypass;
  logic             push;
  logic             pop;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[ptr_w-1] != rd_ptr[ptr_w-1]) &&
                      (wr_ptr[ptr_w-2:0] == rd_ptr[ptr_w-2:0]);
  assign cts        = ready && !fifo_full;

  // A byte that arrives when the serialiser can load and nothing is queued
  // skips the FIFO, so it sees the same latency as the unbuffered build.
  assign bypass     = accept && can_load && fifo_empty;
  assign push       = accept && !bypass;
  assign pop        = can_load && !fifo_empty;
  assign load       = bypass || pop;
  assign load_data  = pop ? mem[rd_ptr[ptr_w-2:0]] : tick_data_in;

  // FIFO pointers. A push and a pop in the same cycle leave the count unchanged.
  always_ff @(posedge clock or negedge tick_reset_n) begin
    if (!tick_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FIFO storage write port.
  // NOTE: the storage array has no reset. The pointers alone decide which
  // entries are valid, and an array without reset can map to RAM.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[ptr_w-2:0]] <= tick_data_in;
  end
`else
  assign fifo_empty = 1'b1;
  assign cts        = can_load;
  assign load       = accept;
  assign load_data  = tick_data_in;
`endif

  // State, counters and shift register.
  // NOTE: sequential state uses non-blocking (<=) assignments, so every flop
  // samples the values from before this edge no matter how the blocks are ordered.
  always_ff @(posedge clock or negedge tick_reset_n) begin
    if (!tick_reset_n) begin
      state     <= IDLE;
      bit_delay <= '0;
      bit_index <= '0;
      shift     <= '0;
      stop_cnt  <= 1'b0;
      ready     <= 1'b0;
    end else begin
      state     <= state_n;
      bit_delay <= bit_delay_n;
      bit_index <= bit_index_n;
      shift     <= shift_n;
      stop_cnt  <= stop_cnt_n;
      ready     <= 1'b1;
    end
  end

  // Running sum of accepted bytes. It wraps at 32 bits.
  always_ff @(posedge clock or negedge tick_reset_n) begin
    if (!tick_reset_n) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= checksum + {24'd0, tick_data_in};
    end
  end

  // Next-state logic: advances the bit timer and steps through the frame.
  // NOTE: every signal gets a hold value first, so no path through the case
  // statement leaves a signal unassigned and infers a latch.
  always_comb begin
    state_n     = state;
    bit_delay_n = bit_delay;
    bit_index_n = bit_index;
    shift_n     = shift;
    stop_cnt_n  = stop_cnt;
    unique case (state)
      IDLE: begin
        if (load) begin
          shift_n     = load_data;
          bit_delay_n = '0;
          state_n     = START;
        end
      end
      START: begin
        if (bit_delay == bd_last) begin
          bit_delay_n = '0;
          bit_index_n = '0;
          state_n     = DATA;
        end else begin
          bit_delay_n = bit_delay + 1'b1;
        end
      end
      DATA: begin
        if (bit_delay == bd_last) begin
          bit_delay_n = '0;
          shift_n     = {1'b0, shift[7:1]};
          if (bit_index == 3'd7) begin
            stop_cnt_n = 1'b0;
            state_n    = STOP;
          end else begin
            bit_index_n = bit_index + 3'd1;
          end
        end else begin
          bit_delay_n = bit_delay + 1'b1;
        end
      end
      STOP: begin
        if (bit_delay == bd_last) begin
          bit_delay_n = '0;
          if (stop_cnt == stop_last) begin
            stop_cnt_n = 1'b0;
            if (load) begin
              // A byte taken here starts the next frame with no idle gap.
              shift_n = load_data;
              state_n = START;
            end else begin
              state_n = IDLE;
            end
          end else begin
            stop_cnt_n = 1'b1;
          end
        end else begin
          bit_delay_n = bit_delay + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Line level decoded from state. Reset forces IDLE at once, so the line
  // goes high in the same cycle that reset is asserted.
  always_comb begin
    get_serial_ret = 1'b1;
    unique case (state)
      START:   get_serial_ret = 1'b0;
      DATA:    get_serial_ret = shift[0];
      default: get_serial_ret = 1'b1;
    endcase
  end

  assign get_cts_ret      = cts;
  assign get_idle_ret     = (state == IDLE) && fifo_empty;
  assign get_checksum_ret = checksum;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx with cycles_per_bit=4
// and stop_bits=1. Inputs change and outputs are sampled on the falling clock
// edge. The DUT acts on the rising edge.

module tb_uart_tx;

  localparam int cpb       = 4;
  localparam int sb        = 1;
  localparam int frame_len = (9 + sb) * cpb;

  logic        clock = 1'b0;
  logic        tick_reset_n = 1'b0;
  logic [7:0]  tick_data_in = 8'h00;
  logic        tick_req = 1'b0;
  logic        get_cts_ret;
  logic        get_serial_ret;
  logic        get_idle_ret;
  logic [31:0] get_checksum_ret;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  uart_tx #(
    .cycles_per_bit(cpb),
    .stop_bits     (sb),
    .fifo_depth    (4)
  ) dut (
    .clock           (clock),
    .tick_reset_n    (tick_reset_n),
    .tick_data_in    (tick_data_in),
    .tick_req        (tick_req),
    .get_cts_ret     (get_cts_ret),
    .get_serial_ret  (get_serial_ret),
    .get_idle_ret    (get_idle_ret),
    .get_checksum_ret(get_checksum_ret)
  );

  // Expected line level for each cycle of one frame, with cycle 0 in bit 0.
  // The frame is start 0, then d[0]..d[7], then stop 1, and each bit lasts 4 cycles.
  // Example: 0xA5 gives 0,1,0,1,0,0,1,0,1,1.
  function automatic logic [39:0] frame_wave(input logic [7:0] d);
    logic [9:0]  f;
    logic [39:0] w;
    f = {1'b1, d, 1'b0};
    for (int i = 0; i < 40; i++) w[i] = f[i/4];
    return w;
  endfunction

  task automatic do_reset();
    @(negedge clock);
    tick_req     = 1'b0;
    tick_data_in = 8'h00;
    tick_reset_n = 1'b0;
    repeat (3) @(negedge clock);
    tick_reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic wait_cts(input string name);
    int n = 0;
    while (!get_cts_ret && n < 500) begin
      @(negedge clock);
      n++;
    end
    if (!get_cts_ret) begin
      errors++;
      checks++;
      $display("FAIL %s: cts timeout, got %b required 1", name, get_cts_ret);
    end
  endtask

  // Present one byte for a single edge. The task returns in the first start-bit cycle.
  task automatic send_byte(input logic [7:0] d, input string name);
    wait_cts(name);
    tick_req     = 1'b1;
    tick_data_in = d;
    @(negedge clock);
    tick_req     = 1'b0;
  endtask

  task automatic capture_frame(output logic [39:0] w);
    for (int i = 0; i < frame_len; i++) begin
      w[i] = get_serial_ret;
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    logic [34:0] obs;
    @(negedge clock);
    tick_reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      obs = {get_serial_ret, get_cts_ret, get_idle_ret, get_checksum_ret};
      checks++;
      if (obs !== {1'b1, 1'b0, 1'b1, 32'd0}) begin
        errors++;
        $display("FAIL reset_hold[%0d]: serial/cts/idle/sum got %h required %h", i, obs,
                 {1'b1, 1'b0, 1'b1, 32'd0});
      end
    end
    tick_reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      obs = {get_serial_ret, get_cts_ret, get_idle_ret, get_checksum_ret};
      checks++;
      if (obs !== {1'b1, 1'b1, 1'b1, 32'd0}) begin
        errors++;
        $display("FAIL reset_idle[%0d]: serial/cts/idle/sum got %h required %h", i, obs,
                 {1'b1, 1'b1, 1'b1, 32'd0});
      end
    end
  endtask

  task automatic test_single_byte();
    logic [39:0] w;
    do_reset();
    send_byte(8'hA5, "single");
    checks++;
    if ({get_idle_ret, get_cts_ret} !== 2'b00) begin
      errors++;
      $display("FAIL single_busy: idle/cts got %b required 00", {get_idle_ret, get_cts_ret});
    end
    capture_frame(w);
    checks++;
    if (w !== frame_wave(8'hA5)) begin
      errors++;
      $display("FAIL single_wave: got %h required %h", w, frame_wave(8'hA5));
    end
    checks++;
    if ({get_serial_ret, get_cts_ret, get_idle_ret} !== 3'b111) begin
      errors++;
      $display("FAIL single_after: serial/cts/idle got %b required 111",
               {get_serial_ret, get_cts_ret, get_idle_ret});
    end
    checks++;
    if (get_checksum_ret !== 32'h0000_00A5) begin
      errors++;
      $display("FAIL single_sum: got %h required 000000a5", get_checksum_ret);
    end
  endtask

  task automatic test_back_to_back();
    logic [79:0] w;
    int cts_hi = 0;
`ifdef UART_TX_FIFO_EN
    int drop_at = 0;
`else
    int drop_at = 39;
`endif
    do_reset();
    wait_cts("b2b");
    tick_req     = 1'b1;
    tick_data_in = 8'h00;
    @(negedge clock);
    tick_data_in = 8'hFF;
    for (int i = 0; i < 2 * frame_len; i++) begin
      w[i] = get_serial_ret;
      if (i < frame_len && get_cts_ret) cts_hi++;
      if (i == frame_len - 1) begin
        checks++;
        if (get_cts_ret !== 1'b1) begin
          errors++;
          $display("FAIL b2b_last_stop_cts: got %b required 1", get_cts_ret);
        end
      end
      @(negedge clock);
      if (i == drop_at) tick_req = 1'b0;
    end
    checks++;
    if (w !== {frame_wave(8'hFF), frame_wave(8'h00)}) begin
      errors++;
      $display("FAIL b2b_wave: got %h required %h", w, {frame_wave(8'hFF), frame_wave(8'h00)});
    end
`ifndef UART_TX_FIFO_EN
    checks++;
    if (cts_hi !== 1) begin
      errors++;
      $display("FAIL b2b_cts_cycles: got %0d required 1", cts_hi);
    end
`endif
    checks++;
    if (get_checksum_ret !== 32'h0000_00FF) begin
      errors++;
      $display("FAIL b2b_sum: got %h required 000000ff", get_checksum_ret);
    end
    checks++;
    if (get_idle_ret !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle: got %b required 1", get_idle_ret);
    end
  endtask

`ifndef UART_TX_FIFO_EN
  task automatic test_ignored_request();
    logic [39:0] w;
    int lows = 0;
    do_reset();
    send_byte(8'h55, "ignored");
    for (int i = 0; i < frame_len; i++) begin
      w[i] = get_serial_ret;
      if (i == 10) begin
        tick_req     = 1'b1;
        tick_data_in = 8'h3C;
      end
      @(negedge clock);
      if (i == 10) tick_req = 1'b0;
    end
    for (int i = 0; i < 20; i++) begin
      if (!get_serial_ret) lows++;
      @(negedge clock);
    end
    checks++;
    if (w !== frame_wave(8'h55)) begin
      errors++;
      $display("FAIL ignored_wave: got %h required %h", w, frame_wave(8'h55));
    end
    checks++;
    if (lows !== 0) begin
      errors++;
      $display("FAIL ignored_no_second_frame: low cycles got %0d required 0", lows);
    end
    checks++;
    if (get_checksum_ret !== 32'h0000_0055) begin
      errors++;
      $display("FAIL ignored_sum: got %h required 00000055", get_checksum_ret);
    end
  endtask
`endif

  task automatic test_reset_mid_frame();
    logic [39:0] w;
    do_reset();
    // 0x37 has bit 3 = 0. Cycle 17 lies inside data bit 3 (cycles 16..19).
    send_byte(8'h37, "midreset");
    repeat (17) @(negedge clock);
    checks++;
    if ({get_serial_ret, get_checksum_ret} !== {1'b0, 32'h37}) begin
      errors++;
      $display("FAIL midreset_before: serial/sum got %h required %h",
               {get_serial_ret, get_checksum_ret}, {1'b0, 32'h37});
    end
    #2;
    tick_reset_n = 1'b0;
    #1;
    checks++;
    if ({get_serial_ret, get_cts_ret, get_idle_ret, get_checksum_ret} !==
        {1'b1, 1'b0, 1'b1, 32'd0}) begin
      errors++;
      $display("FAIL midreset_async: serial/cts/idle/sum got %h required %h",
               {get_serial_ret, get_cts_ret, get_idle_ret, get_checksum_ret},
               {1'b1, 1'b0, 1'b1, 32'd0});
    end
    repeat (3) @(negedge clock);
    tick_reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if (get_cts_ret !== 1'b1) begin
      errors++;
      $display("FAIL midreset_cts_after_release: got %b required 1", get_cts_ret);
    end
    send_byte(8'h81, "midreset_resend");
    capture_frame(w);
    checks++;
    if (w !== frame_wave(8'h81)) begin
      errors++;
      $display("FAIL midreset_wave: got %h required %h", w, frame_wave(8'h81));
    end
    checks++;
    if (get_checksum_ret !== 32'h0000_0081) begin
      errors++;
      $display("FAIL midreset_sum: got %h required 00000081", get_checksum_ret);
    end
  endtask

`ifdef UART_TX_FIFO_EN
  task automatic test_fifo_burst();
    logic [239:0] w;
    logic [239:0] expw;
    int  sent = 0;
    int  idx = 0;
    int  fall_at = -1;
    int  budget = 0;
    logic pending = 1'b0;
    for (int k = 0; k < 6; k++) expw[k*40 +: 40] = frame_wave(8'(k + 1));
    do_reset();
    tick_req     = 1'b1;
    tick_data_in = 8'h01;
    while (idx < 240 && budget < 1000) begin
      // The value decided at the previous falling edge tells whether the rising edge in between accepted a byte.
      if (pending) begin
        sent++;
        if (sent == 6) tick_req = 1'b0;
        else tick_data_in = 8'(sent + 1);
      end
      if (sent >= 1) begin
        w[idx] = get_serial_ret;
        idx++;
      end
      if (!get_cts_ret && fall_at < 0) fall_at = sent;
      pending = tick_req && get_cts_ret;
      @(negedge clock);
      budget++;
    end
    checks++;
    if (idx !== 240) begin
      errors++;
      $display("FAIL fifo_budget: samples got %0d required 240", idx);
    end
    checks++;
    if (fall_at !== 5) begin
      errors++;
      $display("FAIL fifo_cts_fall: accepted when cts fell got %0d required 5", fall_at);
    end
    checks++;
    if (w !== expw) begin
      errors++;
      $display("FAIL fifo_wave: got %h required %h", w, expw);
    end
    checks++;
    if (get_checksum_ret !== 32'h0000_0015) begin
      errors++;
      $display("FAIL fifo_sum: got %h required 00000015", get_checksum_ret);
    end
    checks++;
    if ({get_idle_ret, get_serial_ret} !== 2'b11) begin
      errors++;
      $display("FAIL fifo_idle: idle/serial got %b required 11", {get_idle_ret, get_serial_ret});
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
`ifndef UART_TX_FIFO_EN
    test_ignored_request();
`endif
    test_reset_mid_frame();
`ifdef UART_TX_FIFO_EN
    test_fifo_burst();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
